// File: rtl/seq_ctrl.sv
// Y86-64 sequential-processor sequencer: owns PC, CC and stat, and steps one stage per cycle.
// Latency is 6 cycles per instruction plus one per MEMORY cycle stalled on dmem_ready; run=0 holds in FETCH.
module seq_ctrl #(
  parameter logic [63:0] RESET_PC     = 64'd0,
  parameter int          MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic        instr_valid,
  input  logic        memory_error,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  input  logic        cnd,
  input  logic [2:0]  CC_out,
  input  logic        dmem_ready,
  input  logic        dmem_error,
  output logic [63:0] PC,
  output logic [2:0]  CC_in,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [31:0] instr_count
);

  localparam int WCW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(MEM_WAIT_MAX);
  localparam logic [WCW-1:0] WAIT_ONE = WCW'(1);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_PCUPD     = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [2:0]     state_q, state_d;
  logic [63:0]    pc_q, pc_d;
  logic [2:0]     cc_q, cc_d;
  logic [2:0]     stat_q, stat_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           cnd_q, cnd_d;
  logic [3:0]     icode_q, icode_d;
  logic [3:0]     ifun_q, ifun_d;
  logic [63:0]    valc_q, valc_d;
  logic [63:0]    valp_q, valp_d;
  logic [63:0]    valm_q, valm_d;

  logic        is_mem;
  logic        wb_need;
  logic [63:0] next_pc;

  always_comb begin
    is_mem = 1'b0;
    case (icode_q)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: is_mem = 1'b1;
      default:                                            is_mem = 1'b0;
    endcase
  end

  always_comb begin
    wb_need = 1'b0;
    case (icode_q)
      I_IRMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: wb_need = 1'b1;
      I_CMOVXX:                                                  wb_need = cnd_q;
      default:                                                   wb_need = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = valp_q;
    if (icode_q == I_CALL) begin
      next_pc = valc_q;
    end else if (icode_q == I_JXX && cnd_q) begin
      next_pc = valc_q;
    end else if (icode_q == I_RET) begin
      next_pc = valm_q;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cc_d    = cc_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    cnd_d   = cnd_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    valm_d  = valm_q;

    case (state_q)
      S_FETCH: begin
        if (run) begin
          icode_d = icode;
          ifun_d  = ifun;
          valc_d  = valC;
          valp_d  = valP;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (memory_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode_q == I_HALT) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        cnd_d = cnd;
        if (icode_q == I_OPQ) begin
          cc_d = CC_out;
        end
        state_d = S_MEMORY;
      end
      S_MEMORY: begin
        if (!is_mem) begin
          state_d = S_WRITEBACK;
        end else if (dmem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
          wait_d  = '0;
        end else if (dmem_ready) begin
          valm_d  = valM;
          state_d = S_WRITEBACK;
          wait_d  = '0;
        end else if (wait_q == WAIT_LIM) begin
          // Ready never came within the allowed window: treat as an address fault.
          stat_d  = STAT_ADR;
          state_d = S_HALT;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_WRITEBACK: begin
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        pc_d    = next_pc;
        cnt_d   = cnt_q + 32'd1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        stat_d  = STAT_INS;
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      cc_q    <= 3'b100;
      stat_q  <= STAT_AOK;
      cnt_q   <= 32'd0;
      wait_q  <= '0;
      cnd_q   <= 1'b0;
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      valm_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cc_q    <= cc_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      cnd_q   <= cnd_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      valm_q  <= valm_d;
    end
  end

  // ifun is consumed by the execute stage directly; the held copy is kept for observability only.
  logic unused_ifun;
  assign unused_ifun = ^ifun_q;

  assign PC          = pc_q;
  assign CC_in       = cc_q;
  assign stat        = stat_q;
  assign instr_count = cnt_q;
  assign halted      = (state_q == S_HALT);
  assign fetch_en    = (state_q == S_FETCH) && run;
  assign decode_en   = (state_q == S_DECODE);
  assign execute_en  = (state_q == S_EXECUTE);
  assign mem_en      = (state_q == S_MEMORY) && is_mem;
  assign wb_en       = (state_q == S_WRITEBACK) && wb_need;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: stimulus pushes hand-computed per-instruction results; a negedge monitor pops and checks them.
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [3:0]  icode, ifun;
  logic        instr_valid, memory_error;
  logic [63:0] valC, valP, valM;
  logic        cnd;
  logic [2:0]  CC_out;
  logic        dmem_ready, dmem_error;
  logic [63:0] PC;
  logic [2:0]  CC_in;
  logic        fetch_en, decode_en, execute_en, mem_en, wb_en;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  seq_ctrl #(.RESET_PC(64'd32), .MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .run(run), .icode(icode), .ifun(ifun),
    .instr_valid(instr_valid), .memory_error(memory_error),
    .valC(valC), .valP(valP), .valM(valM), .cnd(cnd), .CC_out(CC_out),
    .dmem_ready(dmem_ready), .dmem_error(dmem_error),
    .PC(PC), .CC_in(CC_in), .fetch_en(fetch_en), .decode_en(decode_en),
    .execute_en(execute_en), .mem_en(mem_en), .wb_en(wb_en),
    .stat(stat), .halted(halted), .instr_count(instr_count)
  );

  typedef struct {
    logic [63:0] pc;
    logic [2:0]  cc;
    logic [31:0] cnt;
    logic [2:0]  st;
    int          cyc;
    int          wb;
    int          mem;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_cnt;

  // Data-memory responder knobs, written only by the stimulus process.
  int   rdy_delay;
  bit   rdy_never;
  bit   err_en;
  int   err_at;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Responder: on the k-th MEMORY cycle with mem_en, ready once k exceeds the delay.
  initial begin
    int k;
    k = 0;
    dmem_ready = 1'b0;
    dmem_error = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        k++;
        dmem_ready = !rdy_never && (k > rdy_delay);
        dmem_error = err_en && (k >= err_at);
      end else begin
        k = 0;
        dmem_ready = 1'b0;
        dmem_error = 1'b0;
      end
    end
  end

  // Monitor: an instruction ends when instr_count moves or halted rises.
  initial begin
    int          cyc, wbn, memn;
    logic [31:0] prev_cnt;
    logic        prev_halt;
    exp_t        e;
    cyc = 0; wbn = 0; memn = 0; prev_cnt = 32'd0; prev_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; wbn = 0; memn = 0; prev_cnt = 32'd0; prev_halt = 1'b0;
      end else begin
        if (instr_count != prev_cnt || (halted && !prev_halt)) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got count=%0d halted=%0b want no event", instr_count, halted);
          end else begin
            e = sb.pop_front();
            chk("pc", PC, e.pc);
            chk("cc", {61'd0, CC_in}, {61'd0, e.cc});
            chk("count", {32'd0, instr_count}, {32'd0, e.cnt});
            chk("stat", {61'd0, stat}, {61'd0, e.st});
            chk("halted", {63'd0, halted}, {63'd0, (e.st != 3'd1)});
            chk("cycles", 64'(cyc), 64'(e.cyc));
            chk("wb_pulses", 64'(wbn), 64'(e.wb));
            chk("mem_cycles", 64'(memn), 64'(e.mem));
          end
          prev_cnt  = instr_count;
          prev_halt = halted;
          cyc = 0; wbn = 0; memn = 0;
        end
        if (!halted) begin
          cyc++;
          if (wb_en)  wbn++;
          if (mem_en) memn++;
        end
      end
    end
  end

  task automatic set_in(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                        input logic [63:0] vm, input logic c, input logic [2:0] cco, input int dly);
    icode     = ic;
    ifun      = 4'h0;
    valC      = vc;
    valP      = vp;
    valM      = vm;
    cnd       = c;
    CC_out    = cco;
    rdy_delay = dly;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                       input logic [63:0] vm, input logic c, input logic [2:0] cco, input int dly,
                       input logic [63:0] e_pc, input logic [2:0] e_cc, input logic [2:0] e_st,
                       input int e_cyc, input int e_wb, input int e_mem);
    exp_t e;
    set_in(ic, vc, vp, vm, c, cco, dly);
    if (e_st == 3'd1) exp_cnt = exp_cnt + 32'd1;
    e.pc = e_pc; e.cc = e_cc; e.cnt = exp_cnt; e.st = e_st;
    e.cyc = e_cyc; e.wb = e_wb; e.mem = e_mem;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    logic [31:0] c0;
    bit          done;
    c0   = instr_count;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (instr_count != c0 || halted) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_done: got no retire/halt in 100 cycles want one");
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    run = 1'b1; instr_valid = 1'b1; memory_error = 1'b0;
    rdy_never = 1'b0; err_en = 1'b0; err_at = 0;
    set_in(4'h1, 64'd0, 64'd0, 64'd0, 1'b0, 3'b000, 0);
    exp_cnt = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", PC, 64'd32);
    chk("rst_cc", {61'd0, CC_in}, 64'b100);
    chk("rst_stat", {61'd0, stat}, 64'd1);
    chk("rst_count", {32'd0, instr_count}, 64'd0);
    chk("rst_en", {59'd0, halted, fetch_en, decode_en, execute_en, mem_en, wb_en}, 64'b010000);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    // Sequence 1: a run of retiring instructions ending in halt.
    do_reset();
    issue(4'h3, 64'h0,   64'd42,  64'h0,  1'b0, 3'b000, 0, 64'd42,  3'b100, 3'd1, 6, 1, 0);
    release_rst();
    wait_done();
    issue(4'h6, 64'h0,   64'd44,  64'h0,  1'b0, 3'b010, 0, 64'd44,  3'b010, 3'd1, 6, 1, 0);
    repeat (2) @(posedge clk);
    #1 chk("cc_before_exec", {61'd0, CC_in}, 64'b100);
    @(posedge clk);
    #1 chk("cc_after_exec", {61'd0, CC_in}, 64'b010);
    wait_done();
    issue(4'h3, 64'h0,   64'h50,  64'h0,  1'b0, 3'b111, 0, 64'h50,  3'b010, 3'd1, 6, 1, 0);
    wait_done();
    issue(4'h7, 64'h100, 64'h2A,  64'h0,  1'b1, 3'b111, 0, 64'h100, 3'b010, 3'd1, 6, 0, 0);
    wait_done();
    issue(4'h7, 64'h100, 64'h2A,  64'h0,  1'b0, 3'b111, 0, 64'h2A,  3'b010, 3'd1, 6, 0, 0);
    wait_done();
    issue(4'h2, 64'h0,   64'h2C,  64'h0,  1'b0, 3'b000, 0, 64'h2C,  3'b010, 3'd1, 6, 0, 0);
    wait_done();
    issue(4'h2, 64'h0,   64'h2E,  64'h0,  1'b1, 3'b000, 0, 64'h2E,  3'b010, 3'd1, 6, 1, 0);
    wait_done();
    issue(4'h9, 64'h0,   64'h30,  64'h80, 1'b0, 3'b000, 3, 64'h80,  3'b010, 3'd1, 9, 1, 4);
    wait_done();
    issue(4'h8, 64'h200, 64'h89,  64'h0,  1'b0, 3'b000, 0, 64'h200, 3'b010, 3'd1, 6, 1, 1);
    wait_done();
    issue(4'h4, 64'h0,   64'h20A, 64'h0,  1'b0, 3'b000, 1, 64'h20A, 3'b010, 3'd1, 7, 0, 2);
    wait_done();
    issue(4'h1, 64'h0,   64'h20B, 64'h0,  1'b0, 3'b000, 0, 64'h20B, 3'b010, 3'd1, 6, 0, 0);
    wait_done();
    issue(4'h0, 64'h0,   64'h20C, 64'h0,  1'b0, 3'b000, 0, 64'h20B, 3'b010, 3'd2, 2, 0, 0);
    wait_done();
    repeat (5) @(negedge clk);
    chk("halt_hold_pc", PC, 64'h20B);
    chk("halt_hold_count", {32'd0, instr_count}, 64'd11);
    chk("halt_hold_en", {59'd0, halted, fetch_en, decode_en, execute_en, mem_en, wb_en}, 64'b100000);

    // Invalid instruction.
    do_reset();
    instr_valid = 1'b0;
    issue(4'h3, 64'h0, 64'd42, 64'h0, 1'b0, 3'b000, 0, 64'd32, 3'b100, 3'd4, 2, 0, 0);
    release_rst();
    wait_done();

    // Instruction address fault outranks both invalid and halt.
    do_reset();
    memory_error = 1'b1;
    instr_valid  = 1'b0;
    issue(4'h0, 64'h0, 64'd42, 64'h0, 1'b0, 3'b000, 0, 64'd32, 3'b100, 3'd3, 2, 0, 0);
    release_rst();
    wait_done();

    // rmmovq with no ready: 15 counted waits, fault on the 16th MEMORY cycle.
    do_reset();
    rdy_never = 1'b1;
    issue(4'h4, 64'h0, 64'd42, 64'h0, 1'b0, 3'b000, 0, 64'd32, 3'b100, 3'd3, 19, 0, 16);
    release_rst();
    wait_done();

    // dmem_error wins over dmem_ready in the same cycle.
    do_reset();
    err_en = 1'b1;
    err_at = 2;
    issue(4'h5, 64'h0, 64'd42, 64'h0, 1'b0, 3'b000, 1, 64'd32, 3'b100, 3'd3, 5, 0, 2);
    release_rst();
    wait_done();

    // Reset mid-wait aborts the instruction with no PC/count update.
    do_reset();
    issue(4'h3, 64'h0, 64'd42, 64'h0, 1'b0, 3'b000, 0, 64'd42, 3'b100, 3'd1, 6, 1, 0);
    release_rst();
    wait_done();
    rdy_never = 1'b1;
    set_in(4'h5, 64'h0, 64'd99, 64'h0, 1'b0, 3'b001, 0);
    repeat (8) @(negedge clk);
    chk("midwait_mem_en", {63'd0, mem_en}, 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_pc", PC, 64'd32);
    chk("abort_count", {32'd0, instr_count}, 64'd0);
    chk("abort_cc_stat", {58'd0, CC_in, stat}, {58'd0, 3'b100, 3'd1});
    chk("abort_en", {59'd0, halted, fetch_en, decode_en, execute_en, mem_en, wb_en}, 64'b010000);
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
